// File: rtl/rx78_plane_fetch.sv
// RX-78 VRAM plane fetcher: reads the six colour planes of a character cell into a shadow
// buffer, transfers them to the plane outputs on swap, and arbitrates CPU access to VRAM.
module rx78_plane_fetch #(
   parameter int unsigned NPLANES = 6
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        fetch_start,
   input  logic [12:0] fetch_addr,
   input  logic        swap,
   output logic [7:0]  fg1,
   output logic [7:0]  fg2,
   output logic [7:0]  fg3,
   output logic [7:0]  bg1,
   output logic [7:0]  bg2,
   output logic [7:0]  bg3,
   output logic [12:0] mem_addr,
   output logic [2:0]  mem_plane,
   output logic        mem_rd,
   output logic        mem_we,
   output logic [7:0]  mem_din,
   input  logic [7:0]  mem_dout,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [2:0]  cpu_plane,
   input  logic [12:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_ack,
   output logic        overrun,
   output logic        underrun,
   input  logic        err_clr
);

   localparam logic [2:0] LastK = 3'(NPLANES - 1);

   typedef enum logic [1:0] {StIdle, StFetch, StCpu, StCpuAck} state_e;

   state_e      state_q, state_d;
   logic [2:0]  k_q, k_d;
   logic [12:0] addr_q, addr_d;
   logic        cap_q;
   logic [2:0]  cap_k_q;
   logic [7:0]  shadow_q [NPLANES];
   logic [7:0]  plane_q [NPLANES];
   logic        valid_q, valid_d;
   logic        load_planes;
   logic [12:0] last_addr_q;
   logic [2:0]  last_plane_q;
   logic        cpu_rd_q, cpu_rd_d;
   logic [7:0]  rdata_q;
   logic        ovr_q, ovr_d, unr_q, unr_d;
   logic        ovr_evt;

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      addr_d    = addr_q;
      cpu_rd_d  = cpu_rd_q;
      mem_rd    = 1'b0;
      mem_we    = 1'b0;
      mem_din   = 8'h00;
      mem_addr  = last_addr_q;
      mem_plane = last_plane_q;
      cpu_ack   = 1'b0;
      ovr_evt   = 1'b0;
      valid_d   = valid_q;
      unique case (state_q)
         StIdle: begin
            if (fetch_start) begin
               addr_d  = fetch_addr;
               k_d     = 3'd0;
               state_d = StFetch;
            end else if (cpu_req) begin
               state_d = StCpu;
            end
         end
         StFetch: begin
            ovr_evt   = fetch_start;
            mem_rd    = 1'b1;
            mem_plane = k_q;
            mem_addr  = addr_q;
            if (k_q == LastK) begin
               k_d     = 3'd0;
               state_d = StIdle;
            end else begin
               k_d = k_q + 3'd1;
            end
         end
         StCpu: begin
            ovr_evt   = fetch_start;
            mem_plane = cpu_plane;
            mem_addr  = cpu_addr;
            mem_rd    = !cpu_we;
            mem_we    = cpu_we;
            mem_din   = cpu_wdata;
            cpu_rd_d  = !cpu_we;
            state_d   = StCpuAck;
         end
         StCpuAck: begin
            ovr_evt = fetch_start;
            cpu_ack = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Final capture sets valid only for the next cycle, so a coincident swap still underruns.
      if (cap_q && cap_k_q == LastK) valid_d = 1'b1;
      load_planes = swap && valid_q;
      if (load_planes) valid_d = 1'b0;
      if (state_q == StIdle && fetch_start) valid_d = 1'b0;

      ovr_d = (ovr_q && !err_clr) || ovr_evt;
      unr_d = (unr_q && !err_clr) || (swap && !valid_q);
   end

   // Read data is forwarded during the ack cycle and held afterwards.
   assign cpu_rdata = (state_q == StCpuAck && cpu_rd_q) ? mem_dout : rdata_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         k_q          <= 3'd0;
         addr_q       <= 13'h0000;
         cap_q        <= 1'b0;
         cap_k_q      <= 3'd0;
         valid_q      <= 1'b0;
         last_addr_q  <= 13'h0000;
         last_plane_q <= 3'd0;
         cpu_rd_q     <= 1'b0;
         rdata_q      <= 8'h00;
         ovr_q        <= 1'b0;
         unr_q        <= 1'b0;
         for (int i = 0; i < int'(NPLANES); i++) begin
            shadow_q[i] <= 8'h00;
            plane_q[i]  <= 8'h00;
         end
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         addr_q       <= addr_d;
         cap_q        <= (state_q == StFetch);
         cap_k_q      <= k_q;
         valid_q      <= valid_d;
         last_addr_q  <= mem_addr;
         last_plane_q <= mem_plane;
         cpu_rd_q     <= cpu_rd_d;
         rdata_q      <= cpu_rdata;
         ovr_q        <= ovr_d;
         unr_q        <= unr_d;
         if (cap_q) shadow_q[cap_k_q] <= mem_dout;
         if (load_planes) plane_q <= shadow_q;
      end
   end

   assign fg1      = plane_q[0];
   assign fg2      = plane_q[1];
   assign fg3      = plane_q[2];
   assign bg1      = plane_q[3];
   assign bg2      = plane_q[4];
   assign bg3      = plane_q[5];
   assign overrun  = ovr_q;
   assign underrun = unr_q;

endmodule

// File: tb/tb_rx78_plane_fetch.sv
// Directed bench for rx78_plane_fetch with a behavioural single-port VRAM (1-cycle read latency).
module tb_rx78_plane_fetch;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        fetch_start = 1'b0;
   logic [12:0] fetch_addr = 13'h0;
   logic        swap = 1'b0;
   logic [7:0]  fg1, fg2, fg3, bg1, bg2, bg3;
   logic [12:0] mem_addr;
   logic [2:0]  mem_plane;
   logic        mem_rd, mem_we;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout = 8'h00;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [2:0]  cpu_plane = 3'd0;
   logic [12:0] cpu_addr = 13'h0;
   logic [7:0]  cpu_wdata = 8'h00;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack, overrun, underrun;
   logic        err_clr = 1'b0;

   int checks = 0;
   int errors = 0;
   int we_cycles = 0;
   int both_cycles = 0;

   logic [7:0] vram [0:65535];

   rx78_plane_fetch #(.NPLANES(6)) dut (
      .clk(clk), .reset_n(reset_n), .fetch_start(fetch_start), .fetch_addr(fetch_addr),
      .swap(swap), .fg1(fg1), .fg2(fg2), .fg3(fg3), .bg1(bg1), .bg2(bg2), .bg3(bg3),
      .mem_addr(mem_addr), .mem_plane(mem_plane), .mem_rd(mem_rd), .mem_we(mem_we),
      .mem_din(mem_din), .mem_dout(mem_dout), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_plane(cpu_plane), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .overrun(overrun), .underrun(underrun),
      .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) begin
         vram[{mem_plane, mem_addr}] <= mem_din;
         we_cycles <= we_cycles + 1;
      end
      if (mem_rd) mem_dout <= vram[{mem_plane, mem_addr}];
      if (mem_rd && mem_we) both_cycles <= both_cycles + 1;
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      cyc(); cyc();
      checks++;
      if ({fg1, fg2, fg3, bg1, bg2, bg3} !== 48'h0) begin
         errors++; $display("FAIL reset_planes got %h want 0", {fg1, fg2, fg3, bg1, bg2, bg3});
      end
      checks++;
      if ({mem_rd, mem_we, mem_addr, mem_plane} !== 18'h0) begin
         errors++; $display("FAIL reset_mem got %b %b %h %h want 0 0 0 0",
                            mem_rd, mem_we, mem_addr, mem_plane);
      end
      checks++;
      if ({cpu_rdata, cpu_ack, overrun, underrun} !== 11'h0) begin
         errors++; $display("FAIL reset_cpu_err got %h %b %b %b want 0 0 0 0",
                            cpu_rdata, cpu_ack, overrun, underrun);
      end
      reset_n = 1'b1;
      cyc();
   endtask

   task automatic test_swap_empty();
      swap = 1'b1;
      cyc();
      swap = 1'b0;
      checks++;
      if ({fg1, fg2, fg3, bg1, bg2, bg3} !== 48'h0 || underrun !== 1'b1) begin
         errors++; $display("FAIL swap_empty got %h unr=%b want 0 unr=1",
                            {fg1, fg2, fg3, bg1, bg2, bg3}, underrun);
      end
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      checks++;
      if (underrun !== 1'b0) begin
         errors++; $display("FAIL underrun_clear got %b want 0", underrun);
      end
   endtask

   task automatic test_fetch();
      fetch_start = 1'b1;
      fetch_addr  = 13'h0EC0;
      cyc();
      fetch_start = 1'b0;
      fetch_addr  = 13'h1555;
      for (int c = 1; c <= 6; c++) begin
         checks++;
         if (mem_rd !== 1'b1 || mem_we !== 1'b0 || mem_plane !== 3'(c - 1)
             || mem_addr !== 13'h0EC0) begin
            errors++; $display("FAIL fetch_read c%0d got rd=%b we=%b p=%0d a=%h want 1 0 %0d 0ec0",
                               c, mem_rd, mem_we, mem_plane, mem_addr, c - 1);
         end
         cyc();
      end
      checks++;
      if (mem_rd !== 1'b0 || mem_addr !== 13'h0EC0 || mem_plane !== 3'd5) begin
         errors++; $display("FAIL fetch_idle_hold got rd=%b a=%h p=%0d want 0 0ec0 5",
                            mem_rd, mem_addr, mem_plane);
      end
      cyc();
      swap = 1'b1;
      cyc();
      swap = 1'b0;
      checks++;
      if ({fg1, fg2, fg3, bg1, bg2, bg3} !== 48'h112233445566 || underrun !== 1'b0) begin
         errors++; $display("FAIL fetch_swap got %h unr=%b want 112233445566 unr=0",
                            {fg1, fg2, fg3, bg1, bg2, bg3}, underrun);
      end
   endtask

   task automatic test_swap_boundary();
      fetch_start = 1'b1;
      fetch_addr  = 13'h0123;
      cyc();
      fetch_start = 1'b0;
      repeat (6) cyc();
      swap = 1'b1;               // final capture cycle
      cyc();
      checks++;
      if ({fg1, fg2, fg3, bg1, bg2, bg3} !== 48'h112233445566 || underrun !== 1'b1) begin
         errors++; $display("FAIL swap_at_capture got %h unr=%b want 112233445566 unr=1",
                            {fg1, fg2, fg3, bg1, bg2, bg3}, underrun);
      end
      cyc();
      checks++;
      if ({fg1, fg2, fg3, bg1, bg2, bg3} !== 48'hA0A1A2A3A4A5) begin
         errors++; $display("FAIL swap_after_capture got %h want a0a1a2a3a4a5",
                            {fg1, fg2, fg3, bg1, bg2, bg3});
      end
      err_clr = 1'b1;            // swap still high: new underrun with clear
      cyc();
      swap = 1'b0;
      checks++;
      if (underrun !== 1'b1 || {fg1, fg2, fg3, bg1, bg2, bg3} !== 48'hA0A1A2A3A4A5) begin
         errors++; $display("FAIL clear_vs_event got unr=%b %h want unr=1 a0a1a2a3a4a5",
                            underrun, {fg1, fg2, fg3, bg1, bg2, bg3});
      end
      cyc();
      err_clr = 1'b0;
      checks++;
      if (underrun !== 1'b0) begin
         errors++; $display("FAIL underrun_clear2 got %b want 0", underrun);
      end
   endtask

   task automatic test_cpu();
      int base;
      base      = we_cycles;
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_plane = 3'd3;
      cpu_addr  = 13'h0100;
      cpu_wdata = 8'hA5;
      cyc();
      checks++;
      if (mem_we !== 1'b1 || mem_rd !== 1'b0 || mem_plane !== 3'd3 || mem_addr !== 13'h0100
          || mem_din !== 8'hA5 || cpu_ack !== 1'b0) begin
         errors++; $display("FAIL cpu_wr_cycle got we=%b rd=%b p=%0d a=%h d=%h ack=%b",
                            mem_we, mem_rd, mem_plane, mem_addr, mem_din, cpu_ack);
      end
      cpu_req = 1'b0;
      cyc();
      checks++;
      if (cpu_ack !== 1'b1 || mem_we !== 1'b0) begin
         errors++; $display("FAIL cpu_wr_ack got ack=%b we=%b want 1 0", cpu_ack, mem_we);
      end
      cyc();
      cpu_req = 1'b1;
      cpu_we  = 1'b0;
      cyc();
      checks++;
      if (mem_rd !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 13'h0100) begin
         errors++; $display("FAIL cpu_rd_cycle got rd=%b we=%b a=%h want 1 0 0100",
                            mem_rd, mem_we, mem_addr);
      end
      cpu_req = 1'b0;
      cyc();
      checks++;
      if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
         errors++; $display("FAIL cpu_rd_ack got ack=%b data=%h want 1 a5", cpu_ack, cpu_rdata);
      end
      cyc(); cyc();
      checks++;
      if (cpu_ack !== 1'b0 || cpu_rdata !== 8'hA5 || we_cycles - base !== 1) begin
         errors++; $display("FAIL cpu_rd_hold got ack=%b data=%h we_cycles=%0d want 0 a5 1",
                            cpu_ack, cpu_rdata, we_cycles - base);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] acks;
      acks      = 8'h00;
      cpu_req   = 1'b1;
      cpu_we    = 1'b0;
      cpu_plane = 3'd3;
      cpu_addr  = 13'h0100;
      for (int c = 1; c <= 7; c++) begin
         cyc();
         acks[c] = cpu_ack;
      end
      cpu_req = 1'b0;
      checks++;
      if (acks !== 8'b0010_0100) begin
         errors++; $display("FAIL back_to_back_acks got %b want 00100100", acks);
      end
      cyc(); cyc();
   endtask

   task automatic test_priority();
      logic saw_ack;
      saw_ack     = 1'b0;
      fetch_start = 1'b1;
      fetch_addr  = 13'h0EC0;
      cpu_req     = 1'b1;
      cpu_we      = 1'b0;
      cpu_plane   = 3'd7;
      cpu_addr    = 13'h1FFF;
      cyc();
      fetch_start = 1'b0;
      checks++;
      if (mem_rd !== 1'b1 || mem_plane !== 3'd0 || mem_addr !== 13'h0EC0) begin
         errors++; $display("FAIL priority_fetch_first got rd=%b p=%0d a=%h want 1 0 0ec0",
                            mem_rd, mem_plane, mem_addr);
      end
      for (int c = 1; c <= 7; c++) begin
         saw_ack |= cpu_ack;
         cyc();
      end
      // cycle 8: CPU access with plane 7 passed straight through
      checks++;
      if (saw_ack !== 1'b0 || mem_plane !== 3'd7 || mem_addr !== 13'h1FFF || mem_rd !== 1'b1) begin
         errors++; $display("FAIL priority_cpu_cycle got early_ack=%b p=%0d a=%h rd=%b",
                            saw_ack, mem_plane, mem_addr, mem_rd);
      end
      cpu_req = 1'b0;
      cyc();
      checks++;
      if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h5A || overrun !== 1'b0) begin
         errors++; $display("FAIL priority_cpu_ack got ack=%b data=%h ovr=%b want 1 5a 0",
                            cpu_ack, cpu_rdata, overrun);
      end
      cyc();
   endtask

   task automatic test_overrun();
      logic bad_addr;
      bad_addr    = 1'b0;
      fetch_start = 1'b1;
      fetch_addr  = 13'h0EC0;
      cyc();
      fetch_start = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         if (mem_addr !== 13'h0EC0 || mem_plane !== 3'(c - 1)) bad_addr = 1'b1;
         if (c == 3) begin
            fetch_start = 1'b1;
            fetch_addr  = 13'h0200;
         end else begin
            fetch_start = 1'b0;
         end
         cyc();
      end
      checks++;
      if (bad_addr !== 1'b0 || overrun !== 1'b1 || mem_rd !== 1'b0) begin
         errors++; $display("FAIL overrun_set got addr_bad=%b ovr=%b rd=%b want 0 1 0",
                            bad_addr, overrun, mem_rd);
      end
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin
         errors++; $display("FAIL overrun_clear got %b want 0", overrun);
      end
      cyc();
   endtask

   task automatic test_reset_mid();
      fetch_start = 1'b1;
      fetch_addr  = 13'h0123;
      cyc();
      fetch_start = 1'b0;
      repeat (3) cyc();          // now in FETCH k=3
      reset_n = 1'b0;
      #1;
      checks++;
      if ({fg1, fg2, fg3, bg1, bg2, bg3} !== 48'h0 || mem_rd !== 1'b0 || mem_addr !== 13'h0
          || mem_plane !== 3'd0 || cpu_rdata !== 8'h00) begin
         errors++; $display("FAIL reset_mid_fetch got %h rd=%b a=%h p=%0d rdata=%h want all 0",
                            {fg1, fg2, fg3, bg1, bg2, bg3}, mem_rd, mem_addr, mem_plane, cpu_rdata);
      end
      cyc();
      reset_n = 1'b1;
      cpu_req = 1'b1;
      cpu_we  = 1'b0;
      cyc();
      checks++;
      if (mem_rd !== 1'b1 || mem_plane !== 3'd7) begin
         errors++; $display("FAIL reset_mid_idle got rd=%b p=%0d want 1 7", mem_rd, mem_plane);
      end
      reset_n = 1'b0;            // abort mid-CPU
      cpu_req = 1'b0;
      cyc();
      reset_n = 1'b1;
      cyc(); cyc(); cyc();
      checks++;
      if (cpu_ack !== 1'b0 || mem_rd !== 1'b0) begin
         errors++; $display("FAIL reset_mid_cpu got ack=%b rd=%b want 0 0", cpu_ack, mem_rd);
      end
   endtask

   initial begin
      for (int p = 0; p < 6; p++) begin
         vram[{3'(p), 13'h0EC0}] = 8'(8'h11 * (p + 1));
         vram[{3'(p), 13'h0123}] = 8'(8'hA0 + p);
      end
      vram[{3'd7, 13'h1FFF}] = 8'h5A;
      test_reset();
      test_swap_empty();
      test_fetch();
      test_swap_boundary();
      test_cpu();
      test_back_to_back();
      test_priority();
      test_overrun();
      test_reset_mid();
      checks++;
      if (both_cycles !== 0) begin
         errors++; $display("FAIL rd_we_exclusive got %0d overlap cycles want 0", both_cycles);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
